// File: rtl/mem_state_gen_if.sv
// -----------------------------------------------------------------------------
// mem_state_gen_if
//   CPU <-> memory-responder bus bundle.
//
//   Request side (driven by the CPU, modport master):
//     req    access request, sampled on the rising clock edge
//     we     1 = write, 0 = read, sampled with req
//     addr   word address, sampled with req
//     wdata  write data, sampled with req
//
//   Response side (driven by the responder, modport slave):
//     state  3-bit status code: FREE=3'b010, STALL=3'b111, ERR=3'b100
//     done   one-cycle completion pulse
//     rdata  read data, held until the next read completes
//     err    one-cycle error pulse (zero unless the error feature is built in)
// -----------------------------------------------------------------------------
interface mem_state_gen_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) ();

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [2:0]        state;
   logic              done;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (
      output req, we, addr, wdata,
      input  state, done, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output state, done, rdata, err
   );

endinterface : mem_state_gen_if

// File: rtl/mem_state_gen.sv
// -----------------------------------------------------------------------------
// mem_state_gen
//   Memory-side responder for the CPU freeze controller. Accepts one read or
//   write at a time, holds the CPU with STALL for WAIT_CYC cycles, then
//   completes the access against an internal word array and reports FREE with
//   a one-cycle done pulse. A request present in the completion cycle is taken
//   straight away, so back-to-back accesses have no idle gap.
//
//   Ports:
//     clk    system clock, rising edge
//     rst    asynchronous, active-low reset
//     bus    mem_state_gen_if.slave: req/we/addr/wdata in,
//            state/done/rdata/err out (all outputs registered)
//
//   Optional build macro:
//     MEM_STATE_ERR_EN  when defined, an out-of-range access completes with
//                       state=ERR and an err pulse, and rdata is held. When
//                       undefined, err is tied low, out-of-range writes are
//                       dropped and out-of-range reads return zero.
// -----------------------------------------------------------------------------
module mem_state_gen #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 200,   // valid addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W
   parameter int WAIT_CYC = 3      // STALL cycles per access, 1..255
) (
   input  logic           clk,
   input  logic           rst,
   mem_state_gen_if.slave bus
);

   localparam logic [2:0]      CODE_FREE  = 3'b010;
   localparam logic [2:0]      CODE_STALL = 3'b111;
`ifdef MEM_STATE_ERR_EN
   localparam logic [2:0]      CODE_ERR   = 3'b100;
`endif
   localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W + 1)'(DEPTH);
   localparam logic [7:0]      WAIT_L     = 8'(WAIT_CYC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } fsm_t;

   // Request captured at acceptance; the CPU may change its pins while frozen.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   fsm_t              fsm_q,   fsm_d;
   logic [7:0]        cnt_q,   cnt_d;
   req_t              lat_q,   lat_d;
   logic [2:0]        code_q,  code_d;
   logic              done_q,  done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_STATE_ERR_EN
   logic              err_q,   err_d;
`endif

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_rd;
   logic              mem_we;

   assign in_range = ({1'b0, lat_q.addr} < DEPTH_L);
   assign mem_idx  = lat_q.addr[IDX_W-1:0];
   assign mem_rd   = mem[mem_idx];

   // Next-state and next-output logic. Outputs are computed one cycle ahead
   // and registered, so the code seen by the CPU is glitch-free.
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      fsm_d   = fsm_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      code_d  = CODE_FREE;
      done_d  = 1'b0;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
`ifdef MEM_STATE_ERR_EN
      err_d   = 1'b0;
`endif

      unique case (fsm_q)
         // The completion cycle accepts a new request exactly like idle does,
         // which is what gives back-to-back accesses without a gap.
         S_IDLE, S_DONE: begin
            if (bus.req) begin
               lat_d.we    = bus.we;
               lat_d.addr  = bus.addr;
               lat_d.wdata = bus.wdata;
               cnt_d       = WAIT_L;
               fsm_d       = S_BUSY;
               code_d      = CODE_STALL;
            end else begin
               fsm_d = S_IDLE;
            end
         end

         // req is not looked at here: the CPU is frozen and a held req must
         // not start a second access.
         S_BUSY: begin
            code_d = CODE_STALL;
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               fsm_d  = S_DONE;
               code_d = CODE_FREE;
               done_d = 1'b1;
               if (in_range) begin
                  if (lat_q.we) begin
                     mem_we = 1'b1;
                  end else begin
                     rdata_d = mem_rd;
                  end
               end else begin
`ifdef MEM_STATE_ERR_EN
                  // Flag the access; write dropped, rdata left as it was.
                  code_d = CODE_ERR;
                  err_d  = 1'b1;
`else
                  // Silently complete; write dropped, read returns zero.
                  if (!lat_q.we) begin
                     rdata_d = '0;
                  end
`endif
               end
            end
         end

         default: fsm_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= S_IDLE;
         cnt_q   <= '0;
         lat_q   <= '0;
         code_q  <= CODE_FREE;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         code_q  <= code_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_STATE_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   // NOTE: the word array is deliberately left out of reset so it can map onto
   // RAM; its contents are undefined until written. An access aborted by reset
   // never writes because mem_we is only raised from the BUSY state.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= lat_q.wdata;
      end
   end

   assign bus.state = code_q;
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;

endmodule : mem_state_gen

// File: doc/mem_state_gen.md
Name: mem_state_gen

Overview:
- Memory-side responder that produces the 3-bit memory status code consumed by the CPU freeze controller.
- Accepts single read/write requests from the CPU and services them from an internal word array with a fixed wait-state latency.
- Drives STALL while an access is in flight and FREE when the bus is idle or the access completes, so the CPU pipeline holds during the access.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 32, data word width in bits.
- DEPTH, 200, number of implemented words; valid addresses are 0..DEPTH-1, and DEPTH <= 2^ADDR_W.
- WAIT_CYC, 3, number of STALL cycles per access; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled at the rising edge.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- state  out  3  status code: FREE=3'b010, STALL=3'b111, ERR=3'b100 (ERR only with the optional feature).
- done  out  1  one-cycle pulse when an access completes.
- rdata  out  DATA_W  read data; valid from the done cycle and held until the next read completes.
- err  out  1  one-cycle error pulse (optional feature only; tied to 0 otherwise).

Behaviour:
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- Reset: rst=0 forces IDLE asynchronously. Reset values: state=FREE, done=0, rdata=0, err=0, wait counter=0, latched request cleared. Array contents are not reset.
- IDLE:
  - state=FREE, done=0.
  - At an edge with req=1: latch we/addr/wdata, load the counter with WAIT_CYC, go to BUSY.
  - state=STALL from the next cycle.
- BUSY:
  - state=STALL.
  - The counter decrements every edge. When the counter equals 1 at an edge, go to DONE.
  - STALL is therefore visible for exactly WAIT_CYC cycles.
  - req is ignored in BUSY; the CPU is frozen, and a held req is not double-counted.
  - Latched inputs are stable; changes on addr/wdata/we during BUSY have no effect.
- BUSY->DONE edge:
  - Write: array[addr] <= wdata.
  - Read: rdata <= array[addr].
- DONE (one cycle):
  - state=FREE, done=1.
  - If req=1 at this edge: latch the new request and go directly to BUSY (back-to-back, no idle cycle). Otherwise go to IDLE.
- Read-after-write to the same address in back-to-back accesses returns the newly written data.
- Write accesses leave rdata unchanged.
- Out-of-range address (addr >= DEPTH) without the feature:
  - Full WAIT_CYC stall still occurs.
  - Write is dropped; read returns 0.
  - done=1 and state=FREE as normal.
- Reset mid-access (rst low during BUSY):
  - Immediate return to IDLE/FREE.
  - A pending write is not performed; rdata is cleared to 0.
- The state code never takes any value other than FREE, STALL or ERR.

Optional Feature:
- Macro: MEM_STATE_ERR_EN.
- Defined: an out-of-range access still stalls WAIT_CYC cycles. The completion cycle then drives state=ERR (3'b100), err=1 and done=1. The write is dropped and rdata is held unchanged (not zeroed). Next state follows the normal DONE rules.
- Undefined: the err port is tied to 0, the ERR code is never driven, and out-of-range handling is as described in Behaviour.

Test Plan:
- Reset (rst=0, then release) -> state=FREE, done=0, rdata=0 on the first cycle after release.
- Write addr=8'h05, wdata=32'hDEADBEEF, WAIT_CYC=3 -> state=STALL for exactly 3 cycles, then 1 cycle of FREE with done=1. A later read of 5 returns 32'hDEADBEEF after 3 STALL cycles.
- Back-to-back: req held high across write 8'h10=32'h1234 then read 8'h10 -> no IDLE gap, STALL 3 / FREE 1 / STALL 3 / FREE 1, rdata=32'h1234 on the second done.
- addr/we toggled during BUSY -> operation uses the values sampled at acceptance, verified by reading back.
- rst pulled low on the 2nd STALL cycle of a write to 8'h20 -> immediate FREE. A subsequent read of 8'h20 returns the prior contents, not the aborted data.
- Read addr=8'd250 (DEPTH=200) -> without macro: done=1, state=FREE, rdata=0. With MEM_STATE_ERR_EN: state=3'b100, err=1 for 1 cycle, rdata unchanged.
